mem_access_stage: RTL and testbench

- MEM-stage datapath and controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Accepts one instruction per cycle from EX/MEM and performs any load or store against data memory through a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Presents registered write-back data and control (reg write enable, mem-to-reg select, dest reg) to MEM/WB.

---
 rtl/mem_access_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX/MEM loads/stores into a req/ack memory access and drives MEM/WB.
// Optional REQ timeout with abort pulse is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic                    mem_read_in,
  input  logic                    mem_write_in,
  input  logic                    mem_size_byte_in,
  input  logic                    reg_write_enable_in,
  input  logic                    mem_to_reg_select_in,
  input  logic [3:0]              dest_reg_in,
  input  logic [31:0]             alu_result_in,
  input  logic [DATA_WIDTH-1:0]   store_data_in,
  output logic                    stall_out,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    valid_out,
  output logic                    reg_write_enable_out,
  output logic                    mem_to_reg_select_out,
  output logic [3:0]              dest_reg_out,
  output logic [DATA_WIDTH-1:0]   wb_data_out,
  output logic                    abort_out
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH/8-1:0] mem_byte_en_q, mem_byte_en_d;
  logic                    valid_q, valid_d;
  logic                    rwe_q, rwe_d;
  logic                    m2r_q, m2r_d;
  logic [3:0]              dest_q, dest_d;
  logic [DATA_WIDTH-1:0]   wb_q, wb_d;
  // Instruction fields held for the duration of an access
  logic                    ld_q, ld_d;
  logic                    byte_q, byte_d;
  logic [1:0]              off_q, off_d;
  logic                    lrwe_q, lrwe_d;
  logic                    lm2r_q, lm2r_d;
  logic [3:0]              ldest_q, ldest_d;
  logic [31:0]             lalu_q, lalu_d;

  logic                    stall;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [DATA_WIDTH-1:0]   load_result;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
`endif

  // Word loads rotate right by the byte offset; byte loads take the rotated low lane.
  always_comb begin
    case (off_q)
      2'd0:    load_word = mem_rdata;
      2'd1:    load_word = {mem_rdata[7:0],  mem_rdata[31:8]};
      2'd2:    load_word = {mem_rdata[15:0], mem_rdata[31:16]};
      default: load_word = {mem_rdata[23:0], mem_rdata[31:24]};
    endcase
    load_result = byte_q ? {{(DATA_WIDTH-8){1'b0}}, load_word[7:0]} : load_word;
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register, so no branch can infer a latch.
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
    valid_d       = valid_q;
    rwe_d         = rwe_q;
    m2r_d         = m2r_q;
    dest_d        = dest_q;
    wb_d          = wb_q;
    ld_d          = ld_q;
    byte_d        = byte_q;
    off_d         = off_q;
    lrwe_d        = lrwe_q;
    lm2r_d        = lm2r_q;
    ldest_d       = ldest_q;
    lalu_d        = lalu_q;
    stall         = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    abort_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!valid_in) begin
          valid_d = 1'b0;
          rwe_d   = 1'b0;
        end else if (mem_read_in || mem_write_in) begin
          stall         = 1'b1;
          state_d       = REQ;
          mem_req_d     = 1'b1;
          valid_d       = 1'b0;
          rwe_d         = 1'b0;
          mem_we_d      = mem_write_in & ~mem_read_in;
          mem_addr_d    = {alu_result_in[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d   = mem_size_byte_in ? {4{store_data_in[7:0]}} : store_data_in;
          mem_byte_en_d = (mem_size_byte_in && !mem_read_in) ? 4'(4'b0001 << alu_result_in[1:0])
                                                              : 4'b1111;
          ld_d          = mem_read_in;
          byte_d        = mem_size_byte_in;
          off_d         = alu_result_in[1:0];
          lrwe_d        = reg_write_enable_in;
          lm2r_d        = mem_to_reg_select_in;
          ldest_d       = dest_reg_in;
          lalu_d        = alu_result_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end else begin
          valid_d = 1'b1;
          rwe_d   = reg_write_enable_in;
          m2r_d   = mem_to_reg_select_in;
          dest_d  = dest_reg_in;
          wb_d    = alu_result_in;
        end
      end

      REQ: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          rwe_d     = lrwe_q;
          m2r_d     = lm2r_q;
          dest_d    = ldest_q;
          wb_d      = ld_q ? load_result : lalu_q;
        end else begin
          stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            stall     = 1'b0;
            state_d   = IDLE;
            mem_req_d = 1'b0;
            valid_d   = 1'b1;
            rwe_d     = 1'b0;
            m2r_d     = lm2r_q;
            dest_d    = ldest_q;
            abort_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset forces IDLE asynchronously, so stall must also drop without waiting for an edge.
  assign stall_out = stall & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= '0;
      valid_q       <= 1'b0;
      rwe_q         <= 1'b0;
      m2r_q         <= 1'b0;
      dest_q        <= '0;
      wb_q          <= '0;
      ld_q          <= 1'b0;
      byte_q        <= 1'b0;
      off_q         <= '0;
      lrwe_q        <= 1'b0;
      lm2r_q        <= 1'b0;
      ldest_q       <= '0;
      lalu_q        <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
      valid_q       <= valid_d;
      rwe_q         <= rwe_d;
      m2r_q         <= m2r_d;
      dest_q        <= dest_d;
      wb_q          <= wb_d;
      ld_q          <= ld_d;
      byte_q        <= byte_d;
      off_q         <= off_d;
      lrwe_q        <= lrwe_d;
      lm2r_q        <= lm2r_d;
      ldest_q       <= ldest_d;
      lalu_q        <= lalu_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
  assign abort_out = abort_q;
`else
  assign abort_out = 1'b0;
`endif

  assign mem_req               = mem_req_q;
  assign mem_we                = mem_we_q;
  assign mem_addr              = mem_addr_q;
  assign mem_wdata             = mem_wdata_q;
  assign mem_byte_en           = mem_byte_en_q;
  assign valid_out             = valid_q;
  assign reg_write_enable_out  = rwe_q;
  assign mem_to_reg_select_out = m2r_q;
  assign dest_reg_out          = dest_q;
  assign wb_data_out           = wb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: directed ALU, load, store, reset and timeout/hang cases.
module tb_mem_access_stage;

  typedef struct {
    logic        rwe;
    logic        m2r;
    logic [3:0]  dest;
    logic [31:0] wb;
    logic        abort;
    logic        chk_wb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_read_in, mem_write_in, mem_size_byte_in;
  logic        reg_write_enable_in, mem_to_reg_select_in;
  logic [3:0]  dest_reg_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        valid_out, reg_write_enable_out, mem_to_reg_select_out;
  logic [3:0]  dest_reg_out;
  logic [31:0] wb_data_out;
  logic        abort_out;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_size_byte_in(mem_size_byte_in), .reg_write_enable_in(reg_write_enable_in),
    .mem_to_reg_select_in(mem_to_reg_select_in), .dest_reg_in(dest_reg_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .reg_write_enable_out(reg_write_enable_out),
    .mem_to_reg_select_out(mem_to_reg_select_out), .dest_reg_out(dest_reg_out),
    .wb_data_out(wb_data_out), .abort_out(abort_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input logic v, rd, wr, by, rwe, m2r, input logic [3:0] dst,
                       input logic [31:0] alu, sd);
    valid_in = v; mem_read_in = rd; mem_write_in = wr; mem_size_byte_in = by;
    reg_write_enable_in = rwe; mem_to_reg_select_in = m2r; dest_reg_in = dst;
    alu_result_in = alu; store_data_in = sd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Issue one memory op, hold it through `waits` unacked REQ cycles, then ack.
  // Returns just after the ack edge; caller drives the next instruction immediately.
  task automatic mem_access(input string tag, input logic rd, wr, by, rwe, m2r,
                            input logic [3:0] dst, input logic [31:0] alu, sd, rdata,
                            input int waits, input logic [31:0] exp_addr, exp_wdata, exp_wb,
                            input logic [3:0] exp_be, input logic exp_we);
    int stalls = 0;
    @(posedge clk); #1;
    drive(1'b1, rd, wr, by, rwe, m2r, dst, alu, sd);
    sb.push_back('{rwe: rwe, m2r: m2r, dest: dst, wb: exp_wb, abort: 1'b0, chk_wb: 1'b1});
    @(negedge clk); if (stall_out) stalls++;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      @(negedge clk); if (stall_out) stalls++;
    end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    check({tag, "_req"},   mem_req, 1);
    check({tag, "_addr"},  mem_addr, exp_addr);
    check({tag, "_we"},    mem_we, exp_we);
    check({tag, "_be"},    mem_byte_en, exp_be);
    if (exp_we) check({tag, "_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_stall_ack"}, stall_out, 0);
    check({tag, "_stall_cycles"}, stalls, waits + 1);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  // Monitor: every cycle MEM/WB sees valid_out, compare against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", {28'd0, dest_reg_out}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("out_rwe",   reg_write_enable_out, mon_e.rwe);
        check("out_dest",  dest_reg_out, mon_e.dest);
        check("out_abort", abort_out, mon_e.abort);
        if (mon_e.chk_wb) begin
          check("out_m2r", mem_to_reg_select_out, mon_e.m2r);
          check("out_wb",  wb_data_out, mon_e.wb);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    idle();

    // Reset state
    @(negedge clk);
    check("rst_mem_req",   mem_req, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_stall",     stall_out, 0);
    check("rst_wb_data",   wb_data_out, 0);
    check("rst_byte_en",   mem_byte_en, 0);
    check("rst_abort",     abort_out, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Plain ALU op: one-cycle latency, never stalls
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h1234, 32'd0);
    sb.push_back('{rwe: 1'b1, m2r: 1'b0, dest: 4'd3, wb: 32'h1234, abort: 1'b0, chk_wb: 1'b1});
    @(negedge clk); check("alu_stall", stall_out, 0);
    @(posedge clk); #1 idle();
    @(negedge clk); check("alu_stall_after", stall_out, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bubble_valid", valid_out, 0);
    check("bubble_rwe",   reg_write_enable_out, 0);
    check("bubble_dest_hold", dest_reg_out, 4'd3);

    // Unaligned word load at 0x102, ack after 3 waiting REQ cycles -> rotated data
    mem_access("ld_word", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h102, 32'd0, 32'hAABB_CCDD,
               3, 32'h100, 32'd0, 32'hCCDD_AABB, 4'b1111, 1'b0);
    idle();
    @(negedge clk); check("ld_word_req_drop", mem_req, 0);

    // Byte store at 0x203, immediate ack, next ALU op accepted right after the ack
    mem_access("st_byte", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h203, 32'h0000_00EE, 32'd0,
               0, 32'h200, 32'hEEEE_EEEE, 32'h203, 4'b1000, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 32'h55, 32'd0);
    sb.push_back('{rwe: 1'b1, m2r: 1'b0, dest: 4'd7, wb: 32'h55, abort: 1'b0, chk_wb: 1'b1});
    @(negedge clk);
    check("st_next_stall", stall_out, 0);
    check("st_req_drop",   mem_req, 0);
    @(posedge clk); #1 idle();

    // Byte load at 0x301 -> lane 1 zero-extended
    mem_access("ld_byte", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'h301, 32'd0, 32'h1122_3344,
               1, 32'h300, 32'd0, 32'h0000_0033, 4'b1111, 1'b0);
    idle();

    // Read and write both set is a load; aligned word load returns data unchanged
    mem_access("ld_rw", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 32'h400, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
               0, 32'h400, 32'd0, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    idle();

    // Word store at 0x506: address aligned down, write-back carries the ALU result
    mem_access("st_word", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 32'h506, 32'h1234_5678, 32'd0,
               2, 32'h504, 32'h1234_5678, 32'h506, 4'b1111, 1'b1);
    idle();

    // Reset asserted mid-REQ: outputs drop without a clock edge, access abandoned
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h700, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); check("mid_req_before", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_valid",   valid_out, 0);
    check("mid_rst_stall",   stall_out, 0);
    idle();
    @(posedge clk); #1 reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 32'hCAFE, 32'd0);
    sb.push_back('{rwe: 1'b1, m2r: 1'b0, dest: 4'hA, wb: 32'hCAFE, abort: 1'b0, chk_wb: 1'b1});
    @(negedge clk); check("post_rst_idle_stall", stall_out, 0);
    @(posedge clk); #1 idle();
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    // No ack: after 4 REQ cycles the access aborts with write-back suppressed
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 32'h600, 32'd0);
    sb.push_back('{rwe: 1'b0, m2r: 1'b1, dest: 4'd9, wb: 32'd0, abort: 1'b1, chk_wb: 1'b0});
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_req_held", mem_req, 1);
      check("to_stall", stall_out, (i == 3) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    check("to_req_drop", mem_req, 0);
    check("to_abort",    abort_out, 1);
    check("to_valid",    valid_out, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_abort_pulse", abort_out, 0);
`else
    // No ack and no timeout: request stays up indefinitely
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 32'h600, 32'd0);
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("hang_req_held", mem_req, 1);
    check("hang_stall",    stall_out, 1);
    check("hang_no_valid", valid_out, 0);
    check("hang_abort",    abort_out, 0);
    #1 reset = 1'b1;
    idle();
    @(posedge clk); #1 reset = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
